// File: rtl/mmio_uart_responder_pkg.sv
// Shared constants for the MMIO UART responder: register offsets, status bit
// positions, IO base address and the register-select encoding.
package mmio_pkg;

    localparam logic [31:0] IO_BASE = 32'h8000_0000;

    localparam logic [7:0] MMIO_CTRL = 8'h00;
    localparam logic [7:0] MMIO_RXD  = 8'h04;
    localparam logic [7:0] MMIO_TXD  = 8'h08;
    localparam logic [7:0] MMIO_CYC  = 8'h10;
    localparam logic [7:0] MMIO_INST = 8'h14;
    localparam logic [7:0] MMIO_CRST = 8'h18;

    localparam int ST_TX_SPACE = 0;
    localparam int ST_RX_AVAIL = 1;
    localparam int ST_TX_OVF   = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_RXD,
        SEL_TXD,
        SEL_CYC,
        SEL_INST,
        SEL_CRST
    } reg_sel_e;

    function automatic logic [31:0] io_abs_addr(input logic [7:0] off);
        return IO_BASE | {24'b0, off};
    endfunction

endpackage

// File: rtl/mmio_uart_responder_if.sv
// CPU-side IO bus between the core's address decode and the responder.
interface mmio_if #(parameter int ADDR_W = 8);
    logic [ADDR_W-1:0] io_addr;
    logic              io_re;
    logic [3:0]        io_we;
    logic [31:0]       io_wdata;
    logic [31:0]       io_rdata;

    modport master (output io_addr, output io_re, output io_we, output io_wdata,
                    input io_rdata);
    modport slave  (input io_addr, input io_re, input io_we, input io_wdata,
                    output io_rdata);
endinterface

// File: rtl/mmio_uart_responder_fifo.sv
// Synchronous FIFO with one extra pointer bit to tell full from empty.
// When full, a pop in the same cycle frees the slot for a simultaneous push.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
endmodule

// File: rtl/mmio_uart_responder.sv
// MMIO responder for UART TX/RX and cycle/instruction counters.
// Build option MMIO_RX_FIFO_EN: RX path becomes a FIFO instead of one holding register.
module mmio_uart_responder
    import mmio_pkg::*;
#(
    parameter int TX_FIFO_DEPTH = 8,
    parameter int RX_FIFO_DEPTH = 8,
    parameter int ADDR_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    mmio_if.slave      bus,
    input  logic       inst_retire,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);
    if (TX_FIFO_DEPTH < 2 || (TX_FIFO_DEPTH & (TX_FIFO_DEPTH - 1)) != 0) begin : g_bad_tx
        $error("TX_FIFO_DEPTH must be a power of two >= 2");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_rx
        $error("RX_FIFO_DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] w_off;
    reg_sel_e          w_sel;
    logic              w_store;
    logic [31:0]       w_rdata;
    logic              w_unused;
    logic              w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0]        w_tx_dout;
    logic              w_rx_accept, w_rx_pop_req, w_rx_avail;
    logic [7:0]        w_rx_byte;
    logic              r_tx_ovf;
    logic              r_rx_en;
    logic [31:0]       r_cyc_cnt, r_inst_cnt;

    assign w_off    = {bus.io_addr[ADDR_W-1:2], 2'b00};
    assign w_store  = |bus.io_we;
    assign w_unused = ^{bus.io_addr[1:0], bus.io_wdata[31:8]};

    always_comb begin
        w_sel = SEL_NONE;
        case (w_off)
            ADDR_W'(MMIO_CTRL): w_sel = SEL_CTRL;
            ADDR_W'(MMIO_RXD):  w_sel = SEL_RXD;
            ADDR_W'(MMIO_TXD):  w_sel = SEL_TXD;
            ADDR_W'(MMIO_CYC):  w_sel = SEL_CYC;
            ADDR_W'(MMIO_INST): w_sel = SEL_INST;
            ADDR_W'(MMIO_CRST): w_sel = SEL_CRST;
            default:            w_sel = SEL_NONE;
        endcase
    end

    assign w_tx_push = bus.io_we[0] && (w_sel == SEL_TXD);
    assign w_tx_pop  = !w_tx_empty && tx_ready;
    assign tx_valid  = !w_tx_empty;
    assign tx_data   = w_tx_empty ? 8'h00 : w_tx_dout;

    io_sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_push),
        .i_din   (bus.io_wdata[7:0]),
        .i_pop   (w_tx_pop),
        .o_dout  (w_tx_dout),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign w_rx_pop_req = bus.io_re && (w_sel == SEL_RXD);
    assign w_rx_accept  = rx_valid && rx_ready;

`ifdef MMIO_RX_FIFO_EN
    logic w_rx_full, w_rx_empty;

    assign rx_ready   = r_rx_en && !w_rx_full;
    assign w_rx_avail = !w_rx_empty;

    io_sync_fifo #(.WIDTH(8), .DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_accept),
        .i_din   (rx_data),
        .i_pop   (w_rx_pop_req),
        .o_dout  (w_rx_byte),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );
`else
    logic       r_hold_valid;
    logic [7:0] r_hold_data;

    assign rx_ready   = r_rx_en && !r_hold_valid;
    assign w_rx_avail = r_hold_valid;
    assign w_rx_byte  = r_hold_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              r_hold_valid <= 1'b0;
        else if (w_rx_accept)                  r_hold_valid <= 1'b1;
        else if (w_rx_pop_req && r_hold_valid) r_hold_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_rx_accept) r_hold_data <= rx_data;
    end
`endif

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_CTRL: begin
                w_rdata[ST_TX_SPACE] = !w_tx_full;
                w_rdata[ST_RX_AVAIL] = w_rx_avail;
                w_rdata[ST_TX_OVF]   = r_tx_ovf;
            end
            SEL_RXD:  if (w_rx_avail) w_rdata[7:0] = w_rx_byte;
            SEL_CYC:  w_rdata = r_cyc_cnt;
            SEL_INST: w_rdata = r_inst_cnt;
            default:  w_rdata = '0;
        endcase
    end

    // rx_ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_en       <= 1'b0;
            r_tx_ovf      <= 1'b0;
            bus.io_rdata  <= '0;
        end else begin
            r_rx_en <= 1'b1;
            if (bus.io_re) bus.io_rdata <= w_rdata;
            if (w_store && w_sel == SEL_CTRL)
                r_tx_ovf <= 1'b0;
            else if (w_tx_push && w_tx_full && !w_tx_pop)
                r_tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else if (w_store && w_sel == SEL_CRST) begin
            r_cyc_cnt  <= '0;
            r_inst_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            if (inst_retire) r_inst_cnt <= r_inst_cnt + 32'd1;
        end
    end
endmodule
